spi_byte_sniffer: RTL and testbench

Passive SPI bus monitor that oversamples SCLK, CS_N, MOSI and MISO in the system clock domain and reassembles full bytes on both data lines. It sits directly upstream of the Manta I/O core and drives its `misobyte_in` / `mosibyte_in` probes with the most recent complete byte pair. It also provides a one-cycle byte strobe, a per-frame byte count and a framing-error strobe for on-chip use.

---
 rtl/spi_sniff_pkg.sv | 23 ++
 rtl/spi_byte_sniffer_if.sv | 10 +
 rtl/spi_sniff_sync.sv | 38 +++
 rtl/spi_byte_sniffer.sv | 154 +++++++++++++++
 tb/tb_spi_byte_sniffer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_sniff_pkg.sv
// Shared types and constants for the passive SPI byte sniffer.
package spi_sniff_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int         BYTE_W        = 8;
  localparam logic [7:0] FRAME_CNT_MAX = 8'hFF;

  // Synchronizer reset levels: chip select idles deasserted, data lines low.
  localparam logic CS_N_RST = 1'b1;
  localparam logic MOSI_RST = 1'b0;
  localparam logic MISO_RST = 1'b0;

  // Packs the per-bit synchronizer reset vector in the order {sclk, cs_n, mosi, miso}.
  // SCLK resets to its idle level so no spurious edge is seen after reset.
  function automatic logic [3:0] sync_rst_val(input logic cpol);
    return {cpol, CS_N_RST, MOSI_RST, MISO_RST};
  endfunction

endpackage

// File: rtl/spi_byte_sniffer_if.sv
// Raw SPI bus as seen by the sniffer; the sniffer only ever listens.
interface spi_byte_sniffer_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, output miso);
  modport slave  (input  sclk, input  cs_n, input  mosi, input  miso);
endinterface

// File: rtl/spi_sniff_sync.sv
// Multi-bit two-flop synchronizer; each bit resets to its own value.
module spi_sniff_sync #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      logic meta_q, meta_d;
      logic sync_q, sync_d;

      // Advance the raw bit one stage per clock.
      always_comb begin
        meta_d = d_i[gi];
        sync_d = meta_q;
      end

      // Two flop stages with a per-bit reset level.
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_q <= RST_VAL[gi];
          sync_q <= RST_VAL[gi];
        end else begin
          meta_q <= meta_d;
          sync_q <= sync_d;
        end
      end

      assign q_o[gi] = sync_q;
    end
  endgenerate

endmodule

// File: rtl/spi_byte_sniffer.sv
// Passive SPI monitor: oversamples the bus and reassembles MOSI/MISO bytes.
module spi_byte_sniffer
  import spi_sniff_pkg::*;
#(
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  spi_byte_sniffer_if.slave   spi,
  output logic [BYTE_W-1:0]   mosibyte_o,
  output logic [BYTE_W-1:0]   misobyte_o,
  output logic                byte_valid_o,
  output logic [7:0]          frame_bytes_o,
  output logic                frame_err_o
);

  // Modes 0 and 3 sample on rising SCLK; modes 1 and 2 on falling.
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  logic [3:0] sync_s;
  logic       sclk_s, cs_n_s, mosi_s, miso_s;

  spi_sniff_sync #(
    .W       (4),
    .RST_VAL (sync_rst_val(CPOL))
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({spi.sclk, spi.cs_n, spi.mosi, spi.miso}),
    .q_o (sync_s)
  );

  assign {sclk_s, cs_n_s, mosi_s, miso_s} = sync_s;

  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] mosi_sh_q, mosi_sh_d;
  logic [BYTE_W-1:0] miso_sh_q, miso_sh_d;
  logic              done_q, done_d;
  logic [BYTE_W-1:0] mosibyte_q, mosibyte_d;
  logic [BYTE_W-1:0] misobyte_q, misobyte_d;
  logic              valid_q, valid_d;
  logic [7:0]        frame_q, frame_d;
  logic              err_q, err_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, sample;

  // Edge detection against the delayed copies of synchronized SCLK and CS_N.
  always_comb begin
    sclk_d    = sclk_s;
    cs_n_d    = cs_n_s;
    sclk_rise = sclk_s & ~sclk_q;
    sclk_fall = ~sclk_s & sclk_q;
    cs_fall   = cs_n_q & ~cs_n_s;
    cs_rise   = ~cs_n_q & cs_n_s;
    // A sample edge coinciding with CS release is dropped by the cs_n_s gate.
    sample    = (SAMPLE_RISE ? sclk_rise : sclk_fall) & ~cs_n_s & (state_q == ACTIVE);
  end

  // Framing FSM, shifters and output register next-state logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    mosi_sh_d  = mosi_sh_q;
    miso_sh_d  = miso_sh_q;
    done_d     = 1'b0;
    mosibyte_d = mosibyte_q;
    misobyte_d = misobyte_q;
    valid_d    = 1'b0;
    frame_d    = frame_q;
    err_d      = 1'b0;

    // Shifters hold the complete byte one cycle after the 8th sample; publish it.
    if (done_q) begin
      mosibyte_d = mosi_sh_q;
      misobyte_d = miso_sh_q;
      valid_d    = 1'b1;
      if (frame_q != FRAME_CNT_MAX) frame_d = frame_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = 3'd0;
          mosi_sh_d = '0;
          miso_sh_d = '0;
          frame_d   = 8'd0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          // A frame ending mid-byte is flagged; the partial byte never reaches the outputs.
          err_d     = (bit_cnt_q != 3'd0);
          bit_cnt_d = 3'd0;
        end else if (sample) begin
          if (MSB_FIRST) begin
            mosi_sh_d = {mosi_sh_q[BYTE_W-2:0], mosi_s};
            miso_sh_d = {miso_sh_q[BYTE_W-2:0], miso_s};
          end else begin
            mosi_sh_d = {mosi_s, mosi_sh_q[BYTE_W-1:1]};
            miso_sh_d = {miso_s, miso_sh_q[BYTE_W-1:1]};
          end
          bit_cnt_d = bit_cnt_q + 3'd1;
          done_d    = (bit_cnt_q == 3'd7);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any byte in flight without a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q     <= CPOL;
      cs_n_q     <= CS_N_RST;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      mosi_sh_q  <= '0;
      miso_sh_q  <= '0;
      done_q     <= 1'b0;
      mosibyte_q <= '0;
      misobyte_q <= '0;
      valid_q    <= 1'b0;
      frame_q    <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      mosi_sh_q  <= mosi_sh_d;
      miso_sh_q  <= miso_sh_d;
      done_q     <= done_d;
      mosibyte_q <= mosibyte_d;
      misobyte_q <= misobyte_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
    end
  end

  assign mosibyte_o    = mosibyte_q;
  assign misobyte_o    = misobyte_q;
  assign byte_valid_o  = valid_q;
  assign frame_bytes_o = frame_q;
  assign frame_err_o   = err_q;

endmodule

// File: tb/tb_spi_byte_sniffer.sv
// Directed bench for spi_byte_sniffer: mode 0 MSB-first and mode 3 LSB-first instances.
module tb_spi_byte_sniffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_byte_sniffer_if bus_a ();
  spi_byte_sniffer_if bus_b ();

  logic [7:0] a_mosibyte, a_misobyte, a_frame_bytes;
  logic       a_valid, a_err;
  logic [7:0] b_mosibyte, b_misobyte, b_frame_bytes;
  logic       b_valid, b_err;

  spi_byte_sniffer #(.CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .spi           (bus_a),
    .mosibyte_o    (a_mosibyte),
    .misobyte_o    (a_misobyte),
    .byte_valid_o  (a_valid),
    .frame_bytes_o (a_frame_bytes),
    .frame_err_o   (a_err)
  );

  spi_byte_sniffer #(.CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .spi           (bus_b),
    .mosibyte_o    (b_mosibyte),
    .misobyte_o    (b_misobyte),
    .byte_valid_o  (b_valid),
    .frame_bytes_o (b_frame_bytes),
    .frame_err_o   (b_err)
  );

  int errors = 0;
  int checks = 0;

  int         va_cnt = 0, ea_cnt = 0, vb_cnt = 0, eb_cnt = 0;
  int         consec_a = 0;
  int         last_lat = 0;
  logic       prev_va = 1'b0;
  time        edge_t = 0;
  logic [7:0] mo_q[$];
  logic [7:0] mi_q[$];

  // Pulse monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (a_valid === 1'b1) begin
      va_cnt++;
      mo_q.push_back(a_mosibyte);
      mi_q.push_back(a_misobyte);
      last_lat = int'((($time - edge_t)) / 10);
      if (prev_va === 1'b1) consec_a++;
    end
    prev_va = a_valid;
    if (a_err === 1'b1) ea_cnt++;
    if (b_valid === 1'b1) vb_cnt++;
    if (b_err === 1'b1) eb_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0, MSB first: data set while SCLK low, sampled on the rising edge.
  task automatic a_bits(input logic [7:0] mo, input logic [7:0] mi, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus_a.sclk = 1'b0;
      bus_a.mosi = mo[7-i];
      bus_a.miso = mi[7-i];
      tick(4);
      bus_a.sclk = 1'b1;
      edge_t     = $time;
      tick(4);
    end
    bus_a.sclk = 1'b0;
  endtask

  // Mode 3, LSB first: data set after the falling edge, sampled on the rising edge.
  task automatic b_bits(input logic [7:0] mo, input logic [7:0] mi);
    for (int i = 0; i < 8; i++) begin
      bus_b.sclk = 1'b0;
      bus_b.mosi = mo[i];
      bus_b.miso = mi[i];
      tick(4);
      bus_b.sclk = 1'b1;
      tick(4);
    end
  endtask

  task automatic a_start();
    bus_a.cs_n = 1'b0;
    tick(4);
  endtask

  task automatic a_end();
    tick(4);
    bus_a.cs_n = 1'b1;
    tick(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.sclk = 1'b0; bus_a.cs_n = 1'b1; bus_a.mosi = 1'b0; bus_a.miso = 1'b0;
    bus_b.sclk = 1'b1; bus_b.cs_n = 1'b1; bus_b.mosi = 1'b0; bus_b.miso = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    $display("reset: a_mosi=%h a_miso=%h a_frame=%0d", a_mosibyte, a_misobyte, a_frame_bytes);
    checks++; if (a_mosibyte !== 8'h00) begin errors++; $display("FAIL reset_mosibyte: got %h expected 00", a_mosibyte); end
    checks++; if (a_misobyte !== 8'h00) begin errors++; $display("FAIL reset_misobyte: got %h expected 00", a_misobyte); end
    checks++; if (a_frame_bytes !== 8'd0) begin errors++; $display("FAIL reset_frame_bytes: got %0d expected 0", a_frame_bytes); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", a_err); end
    checks++; if (b_mosibyte !== 8'h00) begin errors++; $display("FAIL reset_b_mosibyte: got %h expected 00", b_mosibyte); end
  endtask

  task automatic test_single_byte();
    int v0 = va_cnt;
    int e0 = ea_cnt;
    a_start();
    a_bits(8'hA5, 8'h3C, 8);
    a_end();
    $display("single: mosi=%h miso=%h frame=%0d latency=%0d", a_mosibyte, a_misobyte, a_frame_bytes, last_lat);
    checks++; if (va_cnt - v0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", va_cnt - v0); end
    checks++; if (a_mosibyte !== 8'hA5) begin errors++; $display("FAIL single_mosi: got %h expected a5", a_mosibyte); end
    checks++; if (a_misobyte !== 8'h3C) begin errors++; $display("FAIL single_miso: got %h expected 3c", a_misobyte); end
    checks++; if (a_frame_bytes !== 8'd1) begin errors++; $display("FAIL single_frame_bytes: got %0d expected 1", a_frame_bytes); end
    checks++; if (ea_cnt - e0 !== 0) begin errors++; $display("FAIL single_err: got %0d expected 0", ea_cnt - e0); end
    checks++; if (last_lat < 3 || last_lat > 5) begin errors++; $display("FAIL single_latency: got %0d expected 3..5", last_lat); end
  endtask

  task automatic test_back_to_back();
    int v0 = va_cnt;
    mo_q.delete();
    mi_q.delete();
    a_start();
    a_bits(8'h01, 8'h10, 8);
    a_bits(8'h80, 8'h20, 8);
    a_bits(8'hFF, 8'h30, 8);
    a_end();
    $display("b2b: pulses=%0d frame=%0d last mosi=%h miso=%h", va_cnt - v0, a_frame_bytes, a_mosibyte, a_misobyte);
    checks++; if (va_cnt - v0 !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", va_cnt - v0); end
    checks++; if (mo_q.size() < 1 || mo_q[0] !== 8'h01) begin errors++; $display("FAIL b2b_mosi0: got %0d entries expected 01 first", mo_q.size()); end
    checks++; if (mo_q.size() < 2 || mo_q[1] !== 8'h80) begin errors++; $display("FAIL b2b_mosi1: got %0d entries expected 80 second", mo_q.size()); end
    checks++; if (mo_q.size() < 3 || mo_q[2] !== 8'hFF) begin errors++; $display("FAIL b2b_mosi2: got %0d entries expected ff third", mo_q.size()); end
    checks++; if (mi_q.size() < 3 || mi_q[0] !== 8'h10 || mi_q[1] !== 8'h20 || mi_q[2] !== 8'h30) begin errors++; $display("FAIL b2b_miso: got %0d entries expected 10 20 30", mi_q.size()); end
    checks++; if (a_frame_bytes !== 8'd3) begin errors++; $display("FAIL b2b_frame_bytes: got %0d expected 3", a_frame_bytes); end
    checks++; if (consec_a !== 0) begin errors++; $display("FAIL b2b_consecutive_valid: got %0d expected 0", consec_a); end
  endtask

  task automatic test_partial_byte();
    int v0 = va_cnt;
    int e0 = ea_cnt;
    a_start();
    a_bits(8'h66, 8'h99, 8);
    a_bits(8'hF0, 8'h0F, 5);
    a_end();
    $display("partial: errs=%0d mosi=%h miso=%h frame=%0d", ea_cnt - e0, a_mosibyte, a_misobyte, a_frame_bytes);
    checks++; if (ea_cnt - e0 !== 1) begin errors++; $display("FAIL partial_err_pulses: got %0d expected 1", ea_cnt - e0); end
    checks++; if (va_cnt - v0 !== 1) begin errors++; $display("FAIL partial_valid_pulses: got %0d expected 1", va_cnt - v0); end
    checks++; if (a_mosibyte !== 8'h66) begin errors++; $display("FAIL partial_mosi: got %h expected 66", a_mosibyte); end
    checks++; if (a_misobyte !== 8'h99) begin errors++; $display("FAIL partial_miso: got %h expected 99", a_misobyte); end
    checks++; if (a_frame_bytes !== 8'd1) begin errors++; $display("FAIL partial_frame_bytes: got %0d expected 1", a_frame_bytes); end
  endtask

  task automatic test_idle_sclk();
    int v0 = va_cnt;
    int e0 = ea_cnt;
    for (int i = 0; i < 16; i++) begin
      bus_a.sclk = ~bus_a.sclk;
      bus_a.mosi = i[0];
      tick(4);
    end
    tick(4);
    $display("idle_sclk: pulses=%0d bit_cnt=%0d", va_cnt - v0, dut_a.bit_cnt_q);
    checks++; if (va_cnt - v0 !== 0) begin errors++; $display("FAIL idle_valid: got %0d expected 0", va_cnt - v0); end
    checks++; if (ea_cnt - e0 !== 0) begin errors++; $display("FAIL idle_err: got %0d expected 0", ea_cnt - e0); end
    checks++; if (dut_a.bit_cnt_q !== 3'd0) begin errors++; $display("FAIL idle_bit_cnt: got %0d expected 0", dut_a.bit_cnt_q); end
    a_start();
    a_bits(8'h5A, 8'hC3, 8);
    a_end();
    $display("after_idle: mosi=%h miso=%h frame=%0d", a_mosibyte, a_misobyte, a_frame_bytes);
    checks++; if (a_mosibyte !== 8'h5A) begin errors++; $display("FAIL after_idle_mosi: got %h expected 5a", a_mosibyte); end
    checks++; if (a_misobyte !== 8'hC3) begin errors++; $display("FAIL after_idle_miso: got %h expected c3", a_misobyte); end
    checks++; if (a_frame_bytes !== 8'd1) begin errors++; $display("FAIL after_idle_frame_bytes: got %0d expected 1", a_frame_bytes); end
  endtask

  task automatic test_mode3_lsb();
    int v0 = vb_cnt;
    int e0 = eb_cnt;
    bus_b.cs_n = 1'b0;
    tick(4);
    b_bits(8'h01, 8'h96);
    tick(4);
    bus_b.cs_n = 1'b1;
    tick(8);
    $display("mode3: mosi=%h miso=%h frame=%0d", b_mosibyte, b_misobyte, b_frame_bytes);
    checks++; if (vb_cnt - v0 !== 1) begin errors++; $display("FAIL mode3_pulses: got %0d expected 1", vb_cnt - v0); end
    checks++; if (b_mosibyte !== 8'h01) begin errors++; $display("FAIL mode3_mosi: got %h expected 01", b_mosibyte); end
    checks++; if (b_misobyte !== 8'h96) begin errors++; $display("FAIL mode3_miso: got %h expected 96", b_misobyte); end
    checks++; if (b_frame_bytes !== 8'd1) begin errors++; $display("FAIL mode3_frame_bytes: got %0d expected 1", b_frame_bytes); end
    checks++; if (eb_cnt - e0 !== 0) begin errors++; $display("FAIL mode3_err: got %0d expected 0", eb_cnt - e0); end
  endtask

  task automatic test_reset_midbyte();
    int v0 = va_cnt;
    int e0 = ea_cnt;
    a_start();
    a_bits(8'hFF, 8'hFF, 4);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);
    bus_a.cs_n = 1'b1;
    tick(8);
    $display("reset_mid: pulses=%0d errs=%0d mosi=%h frame=%0d", va_cnt - v0, ea_cnt - e0, a_mosibyte, a_frame_bytes);
    checks++; if (va_cnt - v0 !== 0) begin errors++; $display("FAIL rstmid_valid: got %0d expected 0", va_cnt - v0); end
    checks++; if (ea_cnt - e0 !== 0) begin errors++; $display("FAIL rstmid_err: got %0d expected 0", ea_cnt - e0); end
    checks++; if (a_mosibyte !== 8'h00) begin errors++; $display("FAIL rstmid_mosi_cleared: got %h expected 00", a_mosibyte); end
    checks++; if (a_frame_bytes !== 8'd0) begin errors++; $display("FAIL rstmid_frame_cleared: got %0d expected 0", a_frame_bytes); end
    a_start();
    a_bits(8'hC3, 8'h24, 8);
    a_end();
    $display("reset_mid_next: mosi=%h miso=%h frame=%0d", a_mosibyte, a_misobyte, a_frame_bytes);
    checks++; if (va_cnt - v0 !== 1) begin errors++; $display("FAIL rstmid_next_pulses: got %0d expected 1", va_cnt - v0); end
    checks++; if (a_mosibyte !== 8'hC3) begin errors++; $display("FAIL rstmid_next_mosi: got %h expected c3", a_mosibyte); end
    checks++; if (a_misobyte !== 8'h24) begin errors++; $display("FAIL rstmid_next_miso: got %h expected 24", a_misobyte); end
    checks++; if (a_frame_bytes !== 8'd1) begin errors++; $display("FAIL rstmid_next_frame_bytes: got %0d expected 1", a_frame_bytes); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_partial_byte();
    test_idle_sclk();
    test_mode3_lsb();
    test_reset_midbyte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
